// File: rtl/dwc_retry_controller.sv
// dwc_retry_controller: runs one operation at a time through a duplicated-with-comparison datapath, retrying on mismatch.
// Define DWC_CTRL_ERR_CNT_EN to enable the saturating mismatch counter on port_err_count.
module dwc_retry_controller #(
    parameter int DATA_W     = 2,
    parameter int DP_LAT     = 1,
    parameter int MAX_RETRY  = 2,
    parameter int ERR_ACTIVE = 1,
    parameter int CNT_W      = 8
) (
    input  logic              port_clk,
    input  logic              port_rst,
    input  logic              port_req_valid,
    output logic              port_req_ready,
    input  logic [DATA_W-1:0] port_req_data,
    output logic              port_dp_start,
    output logic [DATA_W-1:0] port_dp_data,
    input  logic [DATA_W-1:0] port_dp_result,
    input  logic              port_dp_error,
    output logic              port_rsp_valid,
    input  logic              port_rsp_ready,
    output logic [DATA_W-1:0] port_rsp_data,
    output logic              port_rsp_retried,
    output logic              port_fatal,
    input  logic              port_fatal_clr,
    output logic [CNT_W-1:0]  port_err_count
);
    localparam int LW = $clog2(DP_LAT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {IDLE, RUN, RESP, FATAL} state_t;

    state_t            state, state_nxt;
    logic [LW-1:0]     lat_cnt;
    logic [RW-1:0]     retries;
    logic              retried, sample, mismatch, can_retry;
    logic [DATA_W-1:0] dp_data, rsp_data;

    // lat_cnt counts cycles since the last launch; the sample cycle is DP_LAT after it
    assign sample    = state == RUN && lat_cnt == LW'(DP_LAT);
    assign mismatch  = sample && port_dp_error == 1'(ERR_ACTIVE);
    assign can_retry = int'(retries) < MAX_RETRY;

    always_ff @(posedge port_clk or posedge port_rst) begin
        if (port_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = port_req_valid ? RUN : IDLE;
            RUN:     if (sample) state_nxt = !mismatch ? RESP : can_retry ? RUN : FATAL;
            RESP:    state_nxt = port_rsp_ready ? IDLE : RESP;
            FATAL:   state_nxt = port_fatal_clr ? IDLE : FATAL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge port_clk or posedge port_rst) begin
        if (port_rst) begin
            lat_cnt  <= '0;
            retries  <= '0;
            retried  <= 1'b0;
            dp_data  <= '0;
            rsp_data <= '0;
        end else begin
            lat_cnt <= (state == RUN && !sample) ? lat_cnt + 1'b1 : '0;
            if (state == IDLE && port_req_valid) begin
                dp_data <= port_req_data;
                retries <= '0;
                retried <= 1'b0;
            end
            if (mismatch && can_retry) begin
                retries <= retries + 1'b1;
                retried <= 1'b1;
            end
            if (sample && !mismatch) rsp_data <= port_dp_result;
        end
    end

    assign port_req_ready   = state == IDLE;
    assign port_dp_start    = state == RUN && lat_cnt == '0;
    assign port_dp_data     = dp_data;
    assign port_rsp_valid   = state == RESP;
    assign port_rsp_data    = rsp_data;
    assign port_rsp_retried = state == RESP && retried;
    assign port_fatal       = state == FATAL;

`ifdef DWC_CTRL_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge port_clk or posedge port_rst) begin
        if (port_rst)                       err_cnt <= '0;
        else if (mismatch && !(&err_cnt))   err_cnt <= err_cnt + 1'b1;
    end

    assign port_err_count = err_cnt;
`else
    assign port_err_count = '0;
`endif
endmodule

// File: tb/tb_dwc_retry_controller.sv
// tb_dwc_retry_controller: directed ops against a per-cycle expectation timeline built from the operation schedule.
module tb_dwc_retry_controller;
    localparam int DATA_W = 2, DP_LAT = 1, MAX_RETRY = 2, CNT_W = 2, N = 1024;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DWC_CTRL_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              port_clk = 0, port_rst = 1;
    logic              port_req_valid = 0, port_req_ready;
    logic [DATA_W-1:0] port_req_data = '0;
    logic              port_dp_start;
    logic [DATA_W-1:0] port_dp_data, port_dp_result = '0;
    logic              port_dp_error = 0;
    logic              port_rsp_valid, port_rsp_ready = 0;
    logic [DATA_W-1:0] port_rsp_data;
    logic              port_rsp_retried, port_fatal, port_fatal_clr = 0;
    logic [CNT_W-1:0]  port_err_count;

    dwc_retry_controller #(.DATA_W(DATA_W), .DP_LAT(DP_LAT), .MAX_RETRY(MAX_RETRY), .ERR_ACTIVE(1), .CNT_W(CNT_W)) dut (
        .port_clk(port_clk), .port_rst(port_rst),
        .port_req_valid(port_req_valid), .port_req_ready(port_req_ready), .port_req_data(port_req_data),
        .port_dp_start(port_dp_start), .port_dp_data(port_dp_data),
        .port_dp_result(port_dp_result), .port_dp_error(port_dp_error),
        .port_rsp_valid(port_rsp_valid), .port_rsp_ready(port_rsp_ready), .port_rsp_data(port_rsp_data),
        .port_rsp_retried(port_rsp_retried), .port_fatal(port_fatal), .port_fatal_clr(port_fatal_clr),
        .port_err_count(port_err_count)
    );

    always #5 port_clk = ~port_clk;

    int n_checks = 0, n_fail = 0, cyc = 0, mcnt = 0;
    bit e_ready[N], e_start[N], e_valid[N], e_retr[N], e_fatal[N], inc[N], smp[N], smp_err[N];
    logic [DATA_W-1:0] e_data[N], e_dpd[N], smp_res[N];

    initial for (int t = 0; t < N; t++) begin
        e_ready[t] = 1; e_start[t] = 0; e_valid[t] = 0; e_retr[t] = 0; e_fatal[t] = 0;
        inc[t] = 0; smp[t] = 0; smp_err[t] = 0; e_data[t] = '0; e_dpd[t] = '0; smp_res[t] = '0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge port_clk) cyc <= cyc + 1;

    // Replica model: scheduled values in sample cycles, random noise elsewhere
    always @(posedge port_clk) begin
        #1;
        port_dp_error  = smp[cyc] ? smp_err[cyc] : 1'($urandom);
        port_dp_result = smp[cyc] ? smp_res[cyc] : DATA_W'($urandom);
    end

    always @(negedge port_clk) begin
        if (port_rst) mcnt = 0;
        else begin
            if (CNT_EN && inc[cyc] && mcnt < CNT_MAX) mcnt++;
            check("req_ready", port_req_ready, e_ready[cyc]);
            check("dp_start", port_dp_start, e_start[cyc]);
            check("rsp_valid", port_rsp_valid, e_valid[cyc]);
            check("fatal", port_fatal, e_fatal[cyc]);
            check("err_count", port_err_count, mcnt);
            if (e_valid[cyc]) begin
                check("rsp_data", port_rsp_data, e_data[cyc]);
                check("rsp_retried", port_rsp_retried, e_retr[cyc]);
            end
            if (e_start[cyc]) check("dp_data", port_dp_data, e_dpd[cyc]);
        end
    end

    // One request with errs mismatching samples and hold extra cycles before rsp_ready/fatal_clr
    task automatic op(input logic [DATA_W-1:0] d, input int errs, input int hold);
        int c, l, nl, e;
        bit fat;
        l = DP_LAT + 1;
        c = cyc + 1;
        fat = errs > MAX_RETRY;
        nl = fat ? MAX_RETRY + 1 : errs + 1;
        e = c + nl * l;
        for (int k = 0; k < nl; k++) begin
            e_start[c + k*l] = 1;
            e_dpd[c + k*l] = d;
            smp[c + k*l + DP_LAT] = 1;
            smp_err[c + k*l + DP_LAT] = k < errs;
            smp_res[c + k*l + DP_LAT] = d ^ 2'b10;
            if (k < errs) inc[c + k*l + DP_LAT + 1] = 1;
        end
        for (int t = c; t <= e + hold; t++) begin
            e_ready[t] = 0;
            e_fatal[t] = fat && t >= e;
            e_valid[t] = !fat && t >= e;
            e_data[t] = d ^ 2'b10;
            e_retr[t] = errs > 0;
        end
        port_req_valid = 1;
        port_req_data = d;
        @(posedge port_clk); #1;
        port_req_data = ~d;
        port_fatal_clr = 1;
        @(posedge port_clk); #1;
        port_fatal_clr = 0;
        while (cyc < e + hold) begin @(posedge port_clk); #1; end
        if (fat) port_fatal_clr = 1;
        else port_rsp_ready = 1;
        @(posedge port_clk); #1;
        port_fatal_clr = 0;
        port_rsp_ready = 0;
        port_req_valid = 0;
    endtask

    initial begin
        int a;
        repeat (3) @(posedge port_clk);
        #1 port_rst = 0;
        // all mismatches: three launches then sticky fatal
        fork
            op(2'b00, 3, 2);
            begin
                a = cyc + 1;
                while (cyc < a + 6) @(negedge port_clk);
                check("t3_fatal", port_fatal, 1);
                check("t3_req_ready", port_req_ready, 0);
            end
        join
        @(negedge port_clk);
        check("t3_ready_after_clr", port_req_ready, 1);
        check("t3_err_count", port_err_count, CNT_EN ? 3 : 0);
        @(posedge port_clk); #1;
        // clean op
        fork
            op(2'b11, 0, 0);
            begin
                a = cyc + 1;
                @(negedge port_clk); @(negedge port_clk);
                check("t1_start", port_dp_start, 1);
                @(negedge port_clk); @(negedge port_clk);
                check("t1_rsp_valid", port_rsp_valid, 1);
                check("t1_rsp_data", port_rsp_data, 2'b01);
                check("t1_rsp_retried", port_rsp_retried, 0);
            end
        join
        op(2'b10, 0, 5);
        op(2'b01, 1, 3);
        for (int i = 0; i < 3; i++) op(DATA_W'(i), 0, 0);
        // reset in the sample cycle
        a = cyc;
        e_ready[a+1] = 0; e_start[a+1] = 1; e_dpd[a+1] = 2'b01;
        smp[a+2] = 1; smp_err[a+2] = 0; smp_res[a+2] = 2'b11;
        port_req_valid = 1; port_req_data = 2'b01;
        @(posedge port_clk); #1;
        port_req_valid = 0;
        @(posedge port_clk); #2;
        port_rst = 1;
        #1;
        check("rst_dp_start", port_dp_start, 0);
        check("rst_rsp_valid", port_rsp_valid, 0);
        check("rst_fatal", port_fatal, 0);
        check("rst_err_count", port_err_count, 0);
        check("rst_dp_data", port_dp_data, 0);
        check("rst_rsp_data", port_rsp_data, 0);
        check("rst_req_ready", port_req_ready, 1);
        @(posedge port_clk); @(posedge port_clk); #1;
        port_rst = 0;
        @(negedge port_clk);
        check("rst_release_ready", port_req_ready, 1);
        @(posedge port_clk); #1;
        // one mismatch then match
        fork
            op(2'b01, 1, 0);
            begin
                @(negedge port_clk); @(negedge port_clk);
                check("t2_start0", port_dp_start, 1);
                @(negedge port_clk);
                check("t2_gap", port_dp_start, 0);
                @(negedge port_clk);
                check("t2_start1", port_dp_start, 1);
                @(negedge port_clk); @(negedge port_clk);
                check("t2_rsp_valid", port_rsp_valid, 1);
                check("t2_rsp_retried", port_rsp_retried, 1);
                check("t2_err_count", port_err_count, CNT_EN ? 1 : 0);
            end
        join
        op(2'b11, 3, 0);
        op(2'b10, 2, 1);
        @(negedge port_clk);
        check("t6_err_count_sat", port_err_count, CNT_EN ? 3 : 0);
        @(posedge port_clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
